hamming_secded_decoder_stream: RTL and testbench
================================================

Name: hamming_secded_decoder_stream

Overview:
Parametrised, pipelined Hamming SECDED decoder (single-error-correct, double-error-detect) for any data width, using an extended Hamming code with an overall parity bit.
Sits between the storage/link receive path and the consumer, with a valid/ready stream interface on both sides.
Keeps saturating corrected and uncorrectable event counters for status readout.
DATA_W=4 gives the existing (7,4) bit layout plus one overall-parity MSB, i.e. (8,4).

Parameters:
DATA_W, 4, data bits per word (>=1).
CNT_W, 16, width of each event counter.
Derived (localparam, not overridable):
- R: smallest r with 2^r >= DATA_W+r+1.
- N = DATA_W+R, the Hamming positions.
- CW_W = N+1, the codeword width.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  codeword valid.
in_ready  out  1  decoder can accept a codeword.
in_codeword  in  CW_W  received codeword. Bit i-1 = Hamming position i (1..N); bit N = overall parity.
out_valid  out  1  decoded word valid.
out_ready  in  1  consumer accepts.
out_data  out  DATA_W  corrected data.
out_single_err  out  1  single-bit error was corrected (includes the parity-bit-only case).
out_double_err  out  1  uncorrectable error detected; data passed uncorrected.
out_syndrome  out  R  raw syndrome, for debug.
clr_cnt  in  1  synchronous counter clear.
corr_cnt  out  CNT_W  count of corrected words, saturating.
uncorr_cnt  out  CNT_W  count of uncorrectable words, saturating.

Behaviour:
- Layout:
  - Parity bits sit at power-of-two positions (1,2,4,...).
  - Data bit k occupies the k-th non-power-of-two position, ascending. For DATA_W=4: data[0..3] at positions 3,5,6,7.
  - Syndrome bit j = XOR of all positions p (1..N) with p[j]=1.
  - Overall parity P = XOR of all CW_W bits.
- Classification (stage 1):
  - s=0, P=0: clean.
  - s=0, P=1: error in the overall parity bit only. Single; data unchanged.
  - s!=0, P=1, s<=N: single error; invert position s.
  - s!=0, P=1, s>N (shortened code): double/uncorrectable.
  - s!=0, P=0: double/uncorrectable. No bit inverted.
- Pipeline: two register stages.
  - Stage 1 registers the codeword, syndrome and class.
  - Stage 2 registers the corrected and extracted data plus flags.
  - Latency: exactly 2 cycles from input handshake to out_valid with no backpressure.
  - Throughput: 1 word/cycle.
- Flow control:
  - en2 = out_ready | ~s2_valid.
  - en1 = en2 | ~s1_valid.
  - in_ready = en1 (combinational).
  - A stage captures only when its enable is high. Otherwise it holds data and valid stable.
  - out_* must not change while out_valid=1 and out_ready=0.
  - Bubbles collapse: a stalled full pipeline holds exactly 2 words and accepts none until out_ready.
- Counters:
  - Increment only on an output handshake (out_valid & out_ready) whose flag is set.
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt the same cycle as an increment: the clear wins and the counter reads 0 next cycle.
- Reset:
  - s1_valid, s2_valid, out_valid, flags, out_data, out_syndrome and both counters go to 0.
  - Reset mid-stream discards in-flight words, with no handshake.
  - in_ready = 1 the cycle after reset deasserts.
- All outputs are registered except in_ready.

Decomposition:
- Package hamming_pkg holds:
  - Function calc_r(DATA_W).
  - Function is_pow2.
  - Function data_pos(k), returning the Hamming position of data bit k.
  - Enum err_class_t {CLEAN, SINGLE, PARITY_ONLY, DOUBLE}.
- One combinational sub-module, hamming_secded_syndrome (param DATA_W). It maps codeword to {syndrome, overall parity} and is reusable by a future encoder check.
- Pipeline, correction and counters live in the top module.

Test Plan:
- DATA_W=4, in_codeword 8'h55 (data 4'hB, clean), out_ready=1 -> 2 cycles later out_data=4'hB, both flags 0, syndrome 0; counters unchanged.
- 8'h45 (bit 4 / position 5 flipped) -> out_data=4'hB, single_err=1, syndrome=3'd5, corr_cnt=1.
- 8'hD5 (overall parity bit flipped) -> out_data=4'hB, single_err=1, syndrome=0. Then 8'h56 (two flips) -> double_err=1, syndrome=3'd3, uncorr_cnt=1.
- Backpressure: stream 8'h55, 8'h45, 8'h56 back-to-back with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out_* stable; release -> 3 words in order, none lost or duplicated.
- CNT_W=2: 5 corrected words -> corr_cnt sticks at 3. Assert clr_cnt on a correcting handshake -> corr_cnt=0.
- rst asserted with 2 words in flight -> out_valid=0 and counters 0 next cycle. DATA_W=11 (CW_W=16): random single flips -> all corrected; random double flips -> all flagged double.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the extended-Hamming SECDED blocks.
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAN       = 2'd0,
        SINGLE      = 2'd1,
        PARITY_ONLY = 2'd2,
        DOUBLE      = 2'd3
    } err_class_t;

    // Smallest r such that 2^r covers all data bits, all check bits and the zero syndrome.
    function automatic int calc_r(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Hamming position (1-based) of data bit k: the k-th non-power-of-two position.
    function automatic int data_pos(input int k);
        int p;
        int seen;
        p    = 0;
        seen = -1;
        while (seen < k) begin
            p++;
            if (!is_pow2(p)) begin
                seen++;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hamming_secded_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended Hamming codeword.
module hamming_secded_syndrome
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 4,
    localparam int R      = calc_r(DATA_W),
    localparam int N      = DATA_W + R,
    localparam int CW_W   = N + 1
) (
    input  logic [CW_W-1:0] cw_i,
    output logic [R-1:0]    syndrome_o,
    output logic            parity_o
);

    // Each set position contributes its own index, so the XOR of indices equals the syndrome.
    always_comb begin
        syndrome_o = '0;
        for (int p = 1; p <= N; p++) begin
            if (cw_i[p-1]) begin
                syndrome_o = syndrome_o ^ R'(p);
            end
        end
    end

    assign parity_o = ^cw_i;

endmodule

// File: rtl/hamming_secded_decoder_stream.sv
// Two-stage pipelined SECDED decoder with valid/ready streaming and saturating error counters.
module hamming_secded_decoder_stream
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  CNT_W  = 16,
    localparam int R      = calc_r(DATA_W),
    localparam int N      = DATA_W + R,
    localparam int CW_W   = N + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_single_err,
    output logic              out_double_err,
    output logic [R-1:0]      out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic [R-1:0] syn_c;
    logic         par_c;
    err_class_t   class_c;

    hamming_secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .cw_i       (in_codeword),
        .syndrome_o (syn_c),
        .parity_o   (par_c)
    );

    // A nonzero syndrome pointing past the last position can only come from multiple flips.
    always_comb begin
        class_c = CLEAN;
        if (syn_c == '0) begin
            class_c = par_c ? PARITY_ONLY : CLEAN;
        end else if (par_c && (int'(syn_c) <= N)) begin
            class_c = SINGLE;
        end else begin
            class_c = DOUBLE;
        end
    end

    logic en1, en2;
    logic s1_valid_q, s1_valid_d;
    logic [CW_W-1:0] s1_cw_q, s1_cw_d;
    logic [R-1:0] s1_syn_q, s1_syn_d;
    err_class_t s1_class_q, s1_class_d;

    logic s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic s2_single_q, s2_single_d;
    logic s2_double_q, s2_double_d;
    logic [R-1:0] s2_syn_q, s2_syn_d;

    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    assign en2      = out_ready | ~s2_valid_q;
    assign en1      = en2 | ~s1_valid_q;
    assign in_ready = en1;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        s1_class_d = s1_class_q;
        if (en1) begin
            s1_valid_d = in_valid;
            s1_cw_d    = in_codeword;
            s1_syn_d   = syn_c;
            s1_class_d = class_c;
        end
    end

    logic [CW_W-1:0]   corr_cw_c;
    logic [DATA_W-1:0] data_c;

    // Shift by syndrome then back by one: position s maps to bit s-1, and s=0 yields no flip.
    always_comb begin
        corr_cw_c = s1_cw_q;
        if (s1_class_q == SINGLE) begin
            corr_cw_c = s1_cw_q ^ ((CW_W'(1) << s1_syn_q) >> 1);
        end
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
        localparam int POS = data_pos(gi);
        assign data_c[gi] = corr_cw_c[POS-1];
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_single_d = s2_single_q;
        s2_double_d = s2_double_q;
        s2_syn_d    = s2_syn_q;
        if (en2) begin
            s2_valid_d  = s1_valid_q;
            s2_data_d   = data_c;
            s2_single_d = s1_valid_q && ((s1_class_q == SINGLE) || (s1_class_q == PARITY_ONLY));
            s2_double_d = s1_valid_q && (s1_class_q == DOUBLE);
            s2_syn_d    = s1_syn_q;
        end
    end

    logic out_hs;
    assign out_hs = s2_valid_q & out_ready;

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else begin
            if (out_hs && s2_single_q && (corr_cnt_q != {CNT_W{1'b1}})) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (out_hs && s2_double_q && (uncorr_cnt_q != {CNT_W{1'b1}})) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_cw_q      <= '0;
            s1_syn_q     <= '0;
            s1_class_q   <= CLEAN;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_single_q  <= 1'b0;
            s2_double_q  <= 1'b0;
            s2_syn_q     <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cw_q      <= s1_cw_d;
            s1_syn_q     <= s1_syn_d;
            s1_class_q   <= s1_class_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_single_q  <= s2_single_d;
            s2_double_q  <= s2_double_d;
            s2_syn_q     <= s2_syn_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_data       = s2_data_q;
    assign out_single_err = s2_single_q;
    assign out_double_err = s2_double_q;
    assign out_syndrome   = s2_syn_q;
    assign corr_cnt       = corr_cnt_q;
    assign uncorr_cnt     = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder_stream.sv
// Directed bench for the SECDED stream decoder: (8,4) vector table, backpressure, saturation, reset and a 16-bit code.
module tb_hamming_secded_decoder_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main DATA_W=4, CNT_W=16 instance
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [7:0]  in_cw = '0;
    logic [3:0]  out_data;
    logic        out_se, out_de, clr_cnt = 1'b0;
    logic [2:0]  out_syn;
    logic [15:0] corr_cnt, uncorr_cnt;

    hamming_secded_decoder_stream #(.DATA_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_single_err(out_se), .out_double_err(out_de), .out_syndrome(out_syn),
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    // Saturation instance, CNT_W=2
    logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic [7:0]  s_cw = '0;
    logic [3:0]  s_out_data;
    logic        s_se, s_de, s_clr = 1'b0;
    logic [2:0]  s_syn;
    logic [1:0]  s_corr, s_uncorr;

    hamming_secded_decoder_stream #(.DATA_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_codeword(s_cw),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_single_err(s_se), .out_double_err(s_de), .out_syndrome(s_syn),
        .clr_cnt(s_clr), .corr_cnt(s_corr), .uncorr_cnt(s_uncorr)
    );

    // Wide instance, DATA_W=11 -> CW_W=16
    logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1;
    logic [15:0] w_cw = '0;
    logic [10:0] w_out_data;
    logic        w_se, w_de, w_clr = 1'b0;
    logic [3:0]  w_syn;
    logic [15:0] w_corr, w_uncorr;

    hamming_secded_decoder_stream #(.DATA_W(11), .CNT_W(16)) dut_w11 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_codeword(w_cw),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_single_err(w_se), .out_double_err(w_de), .out_syndrome(w_syn),
        .clr_cnt(w_clr), .corr_cnt(w_corr), .uncorr_cnt(w_uncorr)
    );

    typedef struct {
        logic [7:0] cw;
        logic [3:0] data;
        logic       se;
        logic       de;
        logic [2:0] syn;
    } vec_t;

    vec_t vecs[11];
    vec_t bp_exp[3];
    int   exp_corr = 0;
    int   exp_unc  = 0;
    int   got;
    logic [10:0] wd;
    logic [15:0] wcw;
    int   fi, fj;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] enc11(input logic [10:0] d);
        logic [15:0] cw;
        logic        par;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++) begin
                if (((p >> j) & 1) == 1) par = par ^ cw[p-1];
            end
            cw[(1 << j) - 1] = par;
        end
        cw[15] = ^cw[14:0];
        return cw;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{8'h55, 4'hB, 1'b0, 1'b0, 3'd0};
        vecs[1]  = '{8'h45, 4'hB, 1'b1, 1'b0, 3'd5};
        vecs[2]  = '{8'hD5, 4'hB, 1'b1, 1'b0, 3'd0};
        vecs[3]  = '{8'h56, 4'hB, 1'b0, 1'b1, 3'd3};
        vecs[4]  = '{8'h54, 4'hB, 1'b1, 1'b0, 3'd1};
        vecs[5]  = '{8'h15, 4'hB, 1'b1, 1'b0, 3'd7};
        vecs[6]  = '{8'hFF, 4'hF, 1'b0, 1'b0, 3'd0};
        vecs[7]  = '{8'hFE, 4'hF, 1'b1, 1'b0, 3'd1};
        vecs[8]  = '{8'h80, 4'h0, 1'b1, 1'b0, 3'd0};
        vecs[9]  = '{8'h0C, 4'h1, 1'b0, 1'b1, 3'd7};
        vecs[10] = '{8'h51, 4'hB, 1'b1, 1'b0, 3'd3};
        bp_exp[0] = vecs[0];
        bp_exp[1] = vecs[1];
        bp_exp[2] = vecs[3];

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_flags", 32'({out_se, out_de}), 0);
        chk("rst_syndrome", 32'(out_syn), 0);
        chk("rst_corr_cnt", 32'(corr_cnt), 0);
        chk("rst_uncorr_cnt", 32'(uncorr_cnt), 0);

        // Vector table, one word at a time with out_ready=1
        for (int v = 0; v < 11; v++) begin
            in_valid = 1'b1;
            in_cw    = vecs[v].cw;
            chk("tbl_in_ready", 32'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            chk("tbl_latency_gap", 32'(out_valid), 0);
            @(negedge clk);
            $display("vec %0d cw=%h data=%h se=%0b de=%0b syn=%0d", v, vecs[v].cw,
                     out_data, out_se, out_de, out_syn);
            chk("tbl_out_valid", 32'(out_valid), 1);
            chk("tbl_out_data", 32'(out_data), 32'(vecs[v].data));
            chk("tbl_single_err", 32'(out_se), 32'(vecs[v].se));
            chk("tbl_double_err", 32'(out_de), 32'(vecs[v].de));
            chk("tbl_syndrome", 32'(out_syn), 32'(vecs[v].syn));
            if (vecs[v].se) exp_corr++;
            if (vecs[v].de) exp_unc++;
            @(negedge clk);
            chk("tbl_drained", 32'(out_valid), 0);
            chk("tbl_corr_cnt", 32'(corr_cnt), 32'(exp_corr));
            chk("tbl_uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));
        end

        // Backpressure: three words offered back-to-back while the consumer stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cw     = 8'h55;
        chk("bp_accept0", 32'(in_ready), 1);
        @(negedge clk);
        in_cw = 8'h45;
        chk("bp_accept1", 32'(in_ready), 1);
        @(negedge clk);
        in_cw = 8'h56;
        for (int c = 0; c < 5; c++) begin
            chk("bp_in_ready_low", 32'(in_ready), 0);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_data", 32'({out_data, out_se, out_de, out_syn}), 32'({4'hB, 1'b0, 1'b0, 3'd0}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) in_valid = 1'b0;
            if (out_valid) begin
                $display("bp word %0d data=%h se=%0b de=%0b syn=%0d", got, out_data, out_se, out_de, out_syn);
                if (got < 3) begin
                    chk("bp_order_data", 32'(out_data), 32'(bp_exp[got].data));
                    chk("bp_order_flags", 32'({out_se, out_de}), 32'({bp_exp[got].se, bp_exp[got].de}));
                    chk("bp_order_syn", 32'(out_syn), 32'(bp_exp[got].syn));
                end
                got++;
            end
            @(negedge clk);
        end
        chk("bp_word_count", 32'(got), 3);
        exp_corr++;
        exp_unc++;
        chk("bp_corr_cnt", 32'(corr_cnt), 32'(exp_corr));
        chk("bp_uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));

        // Saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1;
            s_cw       = 8'h45;
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        $display("sat corr_cnt=%0d after 5 corrected words", s_corr);
        chk("sat_corr_cnt", 32'(s_corr), 3);
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        chk("sat_clr", 32'(s_corr), 0);
        s_in_valid = 1'b1;
        s_cw       = 8'h45;
        @(negedge clk);
        s_in_valid = 1'b0;
        @(negedge clk);
        chk("clr_hs_valid", 32'(s_out_valid), 1);
        chk("clr_hs_single", 32'(s_se), 1);
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        chk("clr_wins", 32'(s_corr), 0);
        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_count_after_clr", 32'(s_corr), 1);

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cw     = 8'h55;
        @(negedge clk);
        in_cw = 8'h45;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_full", 32'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        $display("mid-stream reset: out_valid=%0b corr=%0d uncorr=%0d", out_valid, corr_cnt, uncorr_cnt);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_corr_cnt", 32'(corr_cnt), 0);
        chk("midrst_uncorr_cnt", 32'(uncorr_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_discarded", 32'(out_valid), 0);

        // DATA_W=11: random single and double flips
        for (int t = 0; t < 40; t++) begin
            wd  = 11'($urandom_range(0, 2047));
            wcw = enc11(wd);
            fi  = int'($urandom_range(0, 15));
            fj  = (fi + int'($urandom_range(1, 15))) % 16;
            wcw[fi] = ~wcw[fi];
            if (t >= 20) wcw[fj] = ~wcw[fj];
            w_in_valid = 1'b1;
            w_cw       = wcw;
            @(negedge clk);
            w_in_valid = 1'b0;
            for (int c = 0; c < 10 && !w_out_valid; c++) @(negedge clk);
            chk("w11_out_valid", 32'(w_out_valid), 1);
            $display("w11 %0d d=%h cw=%h data=%h se=%0b de=%0b syn=%0d", t, wd, wcw, w_out_data, w_se, w_de, w_syn);
            if (t < 20) begin
                chk("w11_single_data", 32'(w_out_data), 32'(wd));
                chk("w11_single_flags", 32'({w_se, w_de}), 32'(2'b10));
                chk("w11_single_syn", 32'(w_syn), (fi == 15) ? 32'd0 : 32'(fi + 1));
            end else begin
                chk("w11_double_flags", 32'({w_se, w_de}), 32'(2'b01));
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
